// File: rtl/gzip_stream_arbiter.sv
// Round-robin merge of NUM_CH word streams into one block-tagged Deflate input stream.
// Optional per-channel block/cut statistics are built when GZIP_ARB_STATS_EN is defined.
module gzip_stream_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int CH_W            = 2,
  parameter int DATA_W          = 32,
  parameter int MAX_BLOCK_WORDS = 16383,
  parameter int CNT_W           = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_last,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [2*NUM_CH-1:0]      btype_cfg,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_sob,
  output logic                     m_last,
  output logic                     m_cut,
  output logic [CH_W-1:0]          m_chan,
  output logic [1:0]               m_btype,
  output logic                     busy,
  input  logic [CH_W-1:0]          stat_sel,
  output logic [63:0]              stat_data
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state;
  logic [CH_W-1:0]   owner;
  logic [CH_W-1:0]   last_owner;
  logic [1:0]        owner_btype;
  logic [CNT_W-1:0]  word_cnt;
  logic              sob_pend;

  logic [NUM_CH-1:0]   req;
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  int                  grant_off;
  int                  grant_sum;
  logic [CH_W-1:0]     grant_ch;
  logic [1:0]          grant_btype;

  logic [DATA_W-1:0] own_data;
  logic              own_valid;
  logic              own_last;
  logic              out_free;
  logic              accept;
  logic              blk_end;

  assign req = s_valid & ch_enable;

  // Rotate the request vector so bit 0 is the channel after last_owner; the lowest set
  // bit of the rotated vector is then the round-robin winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    req_dbl   = {req, req} >> ({1'b0, last_owner} + 1'b1);
    req_rot   = req_dbl[NUM_CH-1:0];
    grant_off = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) grant_off = i;
    end
    grant_sum = int'(last_owner) + 1 + grant_off;
    if (grant_sum >= NUM_CH) grant_sum = grant_sum - NUM_CH;
    grant_ch    = CH_W'(grant_sum);
    grant_btype = '0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (grant_ch == CH_W'(g)) grant_btype = btype_cfg[2*g +: 2];
    end
  end

  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (owner == CH_W'(g)) begin
        own_data  = s_data[g*DATA_W +: DATA_W];
        own_valid = s_valid[g];
        own_last  = s_last[g];
      end
    end
  end

  assign out_free = !m_valid || m_ready;
  assign accept   = (state == XFER) && own_valid && out_free;
  assign blk_end  = own_last || (word_cnt == CNT_W'(MAX_BLOCK_WORDS - 1));
  assign busy     = (state == XFER) || m_valid;

  always_comb begin
    s_ready = '0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (state == XFER && owner == CH_W'(g)) s_ready[g] = out_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= CH_W'(NUM_CH - 1);
      owner_btype <= '0;
      word_cnt    <= '0;
      sob_pend    <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_sob       <= 1'b0;
      m_last      <= 1'b0;
      m_cut       <= 1'b0;
      m_chan      <= '0;
      m_btype     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= own_data;
        m_chan  <= owner;
        m_btype <= owner_btype;
        m_sob   <= sob_pend;
        m_last  <= blk_end;
        m_cut   <= blk_end && !own_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_sob   <= 1'b0;
        m_last  <= 1'b0;
        m_cut   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|req) begin
            owner       <= grant_ch;
            owner_btype <= grant_btype;
            word_cnt    <= '0;
            sob_pend    <= 1'b1;
            state       <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            sob_pend <= 1'b0;
            word_cnt <= word_cnt + CNT_W'(1);
            if (blk_end) begin
              last_owner <= owner;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GZIP_ARB_STATS_EN
  logic [31:0] blk_cnt [NUM_CH];
  logic [31:0] cut_cnt [NUM_CH];
  logic [63:0] stat_next;

  always_comb begin
    stat_next = '0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (stat_sel == CH_W'(g)) stat_next = {cut_cnt[g], blk_cnt[g]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is reset explicitly because software reads zero after reset.
      for (int g = 0; g < NUM_CH; g++) begin
        blk_cnt[g] <= '0;
        cut_cnt[g] <= '0;
      end
      stat_data <= '0;
    end else begin
      for (int g = 0; g < NUM_CH; g++) begin
        if (m_valid && m_ready && m_last && m_chan == CH_W'(g)) begin
          blk_cnt[g] <= blk_cnt[g] + 32'd1;
          if (m_cut) cut_cnt[g] <= cut_cnt[g] + 32'd1;
        end
      end
      stat_data <= stat_next;
    end
  end
`else
  logic stat_unused;
  assign stat_unused = ^stat_sel;
  assign stat_data   = '0;
`endif

endmodule

// File: tb/tb_gzip_stream_arbiter.sv
// Randomised and directed bench for gzip_stream_arbiter; expected blocks come from a
// transaction-level round-robin model fed by the same per-channel segments as the sources.
module tb_gzip_stream_arbiter;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DATA_W = 32;
  localparam int CAP    = 4;
  localparam int CNT_W  = 3;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        s_valid;
  logic [NUM_CH-1:0]        s_ready;
  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [NUM_CH-1:0]        s_last;
  logic [NUM_CH-1:0]        ch_enable;
  logic [2*NUM_CH-1:0]      btype_cfg;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_W-1:0]        m_data;
  logic                     m_sob;
  logic                     m_last;
  logic                     m_cut;
  logic [CH_W-1:0]          m_chan;
  logic [1:0]               m_btype;
  logic                     busy;
  logic [CH_W-1:0]          stat_sel;
  logic [63:0]              stat_data;

  gzip_stream_arbiter #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
    .MAX_BLOCK_WORDS(CAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .ch_enable(ch_enable), .btype_cfg(btype_cfg),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sob(m_sob), .m_last(m_last), .m_cut(m_cut),
    .m_chan(m_chan), .m_btype(m_btype), .busy(busy),
    .stat_sel(stat_sel), .stat_data(stat_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef logic [32:0] word_q_t[$];
  word_q_t src_q [NUM_CH];
  word_q_t mdl_q [NUM_CH];
  int      grant_log[$];

  logic [NUM_CH-1:0] fire_mask;
  logic [NUM_CH-1:0] stall;
  logic              rand_ready;
  logic [32:0]       drv_w;
  int                cyc = 0;

  // Model state: current expected block and per-channel statistics.
  logic              in_blk;
  int                mdl_own;
  int                mdl_last;
  int                blk_words;
  logic [1:0]        own_bt;
  logic              sob_exp;
  logic [31:0]       mdl_blk [NUM_CH];
  logic [31:0]       mdl_cut [NUM_CH];
  logic              gap_chk;
  int                last_cyc;
  logic              prev_stall;
  logic [39:0]       held_vec;

  function automatic logic [39:0] out_vec();
    return {m_valid, m_data, m_chan, m_btype, m_sob, m_last, m_cut};
  endfunction

  task automatic reset_model();
    for (int c = 0; c < NUM_CH; c++) begin
      src_q[c].delete();
      mdl_q[c].delete();
      mdl_blk[c] = '0;
      mdl_cut[c] = '0;
    end
    in_blk     = 1'b0;
    mdl_last   = NUM_CH - 1;
    stall      = '0;
    fire_mask  = '0;
    prev_stall = 1'b0;
  endtask

  task automatic push_seg(input int ch, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      src_q[ch].push_back({(i == n - 1), base + 32'(i)});
      mdl_q[ch].push_back({(i == n - 1), base + 32'(i)});
    end
  endtask

  // One output word accepted: derive the expected owner from round-robin over
  // channels with pending model data, then compare against the next queued word.
  task automatic model_word();
    logic [32:0] w;
    logic        found;
    logic        end_exp;
    logic        cut_exp;
    if (!in_blk) begin
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
        int c;
        c = (mdl_last + i) % NUM_CH;
        if (!found && mdl_q[c].size() > 0 && ch_enable[c]) begin
          found   = 1'b1;
          mdl_own = c;
        end
      end
      if (!found) begin
        check("spurious_word", m_valid, 1'b0);
        return;
      end
      in_blk    = 1'b1;
      blk_words = 0;
      own_bt    = btype_cfg[2*mdl_own +: 2];
      sob_exp   = 1'b1;
      grant_log.push_back(mdl_own);
      if (gap_chk && last_cyc >= 0) check("bubble_gap", 64'(cyc - last_cyc), 64'd2);
    end
    w = mdl_q[mdl_own].pop_front();
    blk_words++;
    end_exp = w[32] || (blk_words == CAP);
    cut_exp = end_exp && !w[32];
    check("data", m_data, w[31:0]);
    check("ctrl", {m_chan, m_btype, m_sob, m_last, m_cut},
          {CH_W'(mdl_own), own_bt, sob_exp, end_exp, cut_exp});
    sob_exp = 1'b0;
    if (end_exp) begin
      in_blk   = 1'b0;
      mdl_last = mdl_own;
      mdl_blk[mdl_own] = mdl_blk[mdl_own] + 32'd1;
      if (cut_exp) mdl_cut[mdl_own] = mdl_cut[mdl_own] + 32'd1;
      last_cyc = cyc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples mid-cycle when inputs and outputs are settled for the next edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      fire_mask = s_valid & s_ready;
      if (prev_stall) check("hold_stable", out_vec(), held_vec);
      if (m_valid && !m_ready) check("stall_sready", s_ready, '0);
      prev_stall = m_valid && !m_ready;
      held_vec   = out_vec();
      if (m_valid && m_ready) model_word();
    end else begin
      fire_mask  = '0;
      prev_stall = 1'b0;
    end
  end

  // Sources: retire words taken at the edge, then present each queue head.
  initial forever begin
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fire_mask[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    end
    fire_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() > 0 && !stall[c]) begin
        drv_w = src_q[c][0];
        s_valid[c] = 1'b1;
        s_last[c]  = drv_w[32];
        s_data[c*DATA_W +: DATA_W] = drv_w[31:0];
      end else begin
        s_valid[c] = 1'b0;
        s_last[c]  = 1'b0;
      end
    end
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic all_idle();
    logic e;
    e = 1'b1;
    for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() > 0) e = 1'b0;
    return e && !m_valid && !busy && !in_blk;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", all_idle(), 1'b1);
  endtask

  task automatic read_stats(input int ch);
    stat_sel = CH_W'(ch);
    tick();
`ifdef GZIP_ARB_STATS_EN
    check("stats", stat_data, {mdl_cut[ch], mdl_blk[ch]});
`else
    check("stats_off", stat_data, 64'd0);
`endif
  endtask

  // Waits at mid-cycle for the first word of a block owned by ch.
  task automatic wait_sob(input int ch, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_sob && m_chan == CH_W'(ch)) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    int   gl0;
    int   t0;
    int   n0;
    logic seen;
    rst_n      = 1'b0;
    s_valid    = '0;
    s_last     = '0;
    s_data     = '0;
    ch_enable  = '1;
    btype_cfg  = '0;
    stat_sel   = '0;
    m_ready    = 1'b1;
    rand_ready = 1'b0;
    gap_chk    = 1'b0;
    last_cyc   = -1;
    reset_model();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("rst_out", out_vec(), '0);
    check("rst_ready_busy", {s_ready, busy}, '0);
    read_stats(0);

    // Round robin with all channels requesting: order 0,1,2,3,0 and one bubble per boundary.
    gl0 = grant_log.size();
    last_cyc = -1;
    gap_chk  = 1'b1;
    push_seg(0, 2, 32'h100);
    push_seg(0, 2, 32'h110);
    push_seg(1, 2, 32'h200);
    push_seg(2, 2, 32'h300);
    push_seg(3, 2, 32'h400);
    wait_drain(200);
    gap_chk = 1'b0;
    check("rr_blocks", 64'(grant_log.size() - gl0), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (gl0 + k < grant_log.size()) check("rr_order", 64'(grant_log[gl0 + k]), 64'(k % NUM_CH));
    end

    // Single channel, fixed-Huffman mode, first-word latency.
    btype_cfg[3:2] = 2'b01;
    push_seg(1, 3, 32'hA1);
    seen = 1'b0;
    t0   = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (s_valid[1]) begin
        seen = 1'b1;
        t0   = cyc;
      end
    end
    check("lat_svalid_seen", seen, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (m_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("lat_mvalid_seen", seen, 1'b1);
    check("lat_cycles", 64'(cyc - t0), 64'd2);
    wait_drain(100);

    // Length cap: 6-word segment splits into a cut 4-word block and a 2-word tail.
    push_seg(2, 6, 32'hC0);
    wait_drain(100);
    read_stats(2);

    // Output backpressure for 5 cycles mid-block.
    push_seg(3, 4, 32'hD0);
    wait_sob(3, "hold_sob_seen");
    tick();
    m_ready = 1'b0;
    repeat (3) tick();
    check("hold_mvalid", m_valid, 1'b1);
    check("hold_sready3", s_ready[3], 1'b0);
    repeat (2) tick();
    m_ready = 1'b1;
    wait_drain(100);

    // Owner drops s_valid mid-block; s_last and the cap coincide on word 4.
    push_seg(1, 4, 32'hE0);
    wait_sob(1, "drop_sob_seen");
    tick();
    stall[1] = 1'b1;
    repeat (6) tick();
    check("drop_busy", busy, 1'b1);
    check("drop_mvalid", m_valid, 1'b0);
    stall[1] = 1'b0;
    wait_drain(100);

    // Disabling the owner lets its block finish but blocks further grants.
    push_seg(0, 3, 32'h500);
    push_seg(0, 3, 32'h510);
    push_seg(1, 2, 32'h600);
    wait_sob(0, "dis_sob_seen");
    tick();
    ch_enable[0] = 1'b0;
    gl0 = grant_log.size();
    repeat (20) tick();
    n0 = 0;
    for (int k = gl0; k < grant_log.size(); k++) if (grant_log[k] == 0) n0++;
    check("dis_no_grant", 64'(n0), 64'd0);
    check("dis_pending", 64'(src_q[0].size()), 64'd3);
    ch_enable[0] = 1'b1;
    wait_drain(100);

    // Randomised rounds: random enables, modes, segments and output backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      ch_enable = 4'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++) btype_cfg[2*c +: 2] = 2'($urandom_range(0, 1));
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_enable[c] && $urandom_range(0, 1) == 1) push_seg(c, $urandom_range(1, 7), $urandom);
        if (ch_enable[c] && $urandom_range(0, 2) == 0) push_seg(c, $urandom_range(1, 7), $urandom);
      end
      wait_drain(500);
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    ch_enable  = '1;
    tick();
    for (int c = 0; c < NUM_CH; c++) read_stats(c);

    // Reset in the middle of a block, then channel 0 must win over channel 3.
    push_seg(1, 4, 32'hF0);
    wait_sob(1, "rst_sob_seen");
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_out", out_vec(), '0);
    check("rst_mid_ready_busy", {s_ready, busy}, '0);
    reset_model();
    repeat (2) tick();
    rst_n = 1'b1;
    read_stats(1);
    gl0 = grant_log.size();
    push_seg(0, 2, 32'h10);
    push_seg(3, 2, 32'h30);
    wait_drain(100);
    check("rst_first_grant_n", 64'(grant_log.size() - gl0), 64'd2);
    if (grant_log.size() > gl0) check("rst_first_grant", 64'(grant_log[gl0]), 64'd0);
    read_stats(0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/gzip_stream_arbiter.md
# gzip_stream_arbiter

Multi-channel front-end for the Deflate core. It merges up to `NUM_CH` independent 32-bit host streams into the single compressor input, one block at a time, using round-robin arbitration. Each forwarded block is tagged with its channel number and that channel's compression mode. Blocks are cut at the stored-block length limit. The block sits between the per-channel input FIFOs and `gzip_top`, in the core clock domain.

## Interface
Parameters:
- `NUM_CH`, 4: number of input channels (2..16).
- `CH_W`, 2: channel index width, equal to clog2(`NUM_CH`).
- `DATA_W`, 32: word width.
- `MAX_BLOCK_WORDS`, 16383: maximum words per forwarded block (16383 × 4 = 65532 bytes, within the Deflate LEN limit).
- `CNT_W`, 14: block word counter width, equal to clog2(`MAX_BLOCK_WORDS`+1).

Ports:
- `clk` in 1: core clock. One clock only; all logic is on `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in `NUM_CH`: per-channel word valid.
- `s_ready` out `NUM_CH`: per-channel word accepted.
- `s_data` in `NUM_CH`*`DATA_W`: channel g occupies bits [g*`DATA_W` +: `DATA_W`].
- `s_last` in `NUM_CH`: last word of the channel's stream segment.
- `ch_enable` in `NUM_CH`: channel may win arbitration.
- `btype_cfg` in 2*`NUM_CH`: per-channel BTYPE (00 stored, 01 fixed Huffman).
- `m_valid` out 1, `m_ready` in 1: output handshake.
- `m_data` out `DATA_W`: output word.
- `m_sob` out 1: first word of a block.
- `m_last` out 1: last word of a block.
- `m_cut` out 1: valid with `m_last`; the block was ended by the length cap, not by `s_last`.
- `m_chan` out `CH_W`: owner channel.
- `m_btype` out 2: owner's BTYPE, latched at grant time.
- `busy` out 1: FSM is in XFER or `m_valid` is high.
- `stat_sel` in `CH_W`: statistics channel select.
- `stat_data` out 64: {cut count[31:0], block count[31:0]} for the selected channel.

## Operation
- FSM states: IDLE and XFER.
- IDLE:
  - req = `s_valid` & `ch_enable`.
  - If req ≠ 0, grant the first requesting channel, searching upward from `last_owner`+1 modulo `NUM_CH`.
  - On grant: latch owner, latch `btype_cfg[owner]`, clear the word counter, set `sob_pend`, go to XFER.
  - If req = 0, stay in IDLE.
- XFER:
  - `s_ready[owner]` = (!`m_valid` | `m_ready`). All other `s_ready` bits are 0.
  - On each accepted word:
    - Load the output register with data, chan and btype.
    - `m_sob` = `sob_pend`; clear `sob_pend`.
    - Increment the counter.
  - Block end happens on the accepted word where `s_last`=1 or counter = `MAX_BLOCK_WORDS`-1.
  - At block end: `m_last`=1, `m_cut` = !`s_last`, `last_owner` = owner, go to IDLE.
- After a cut, the owner re-arbitrates like any other channel. Its continuation block starts with `m_sob`=1.
- `ch_enable` and `btype_cfg` are sampled only at grant. Changes during a block take effect at the next grant.
- If the owner drops `s_valid` mid-block, the FSM waits in XFER indefinitely. There is no timeout.
- Reset clears: FSM to IDLE, `last_owner` = `NUM_CH`-1 (so channel 0 wins first), `m_valid`/`m_sob`/`m_last`/`m_cut` = 0, `m_data`/`m_chan`/`m_btype` = 0, `s_ready` = 0, `busy` = 0, all counters = 0. Reset asserted mid-block discards the partial block.

## Timing
- Arbitration latency:
  - Grant is registered: IDLE to XFER takes 1 cycle.
  - The first word is accepted in the first XFER cycle.
  - `m_valid` rises 2 cycles after `s_valid` is seen in IDLE.
- Throughput: 1 word/cycle while `m_ready`=1. There is exactly one bubble cycle (IDLE) between consecutive blocks.
- Output register: while `m_valid`=1 and `m_ready`=0, all `m_*` outputs hold stable, and `s_ready` is 0.
- A word is transferred on a cycle where `m_valid` & `m_ready`. A new word may load on the same cycle.
- When `s_last` and the cap coincide on the same word: `m_last`=1, `m_cut`=0.

## Configuration
- `GZIP_ARB_STATS_EN` defined:
  - Each channel has a 32-bit block counter, incremented on each `m_last` transfer.
  - Each channel has a 32-bit cut counter, incremented on each `m_cut` transfer.
  - Both counters wrap at 2^32 and reset to 0.
  - `stat_data` is registered, with 1-cycle latency from `stat_sel`.
- `GZIP_ARB_STATS_EN` not defined: no counters are built, and `stat_data` is tied to 0. Ports are unchanged.

## Test plan
- Channel 1 only: 3 words 0xA1,0xA2,0xA3 with `s_last` on 0xA3, `btype_cfg[1]`=01 → `m_data` A1,A2,A3 with `m_chan`=1, `m_btype`=01, `m_sob` on A1, `m_last` on A3, `m_cut`=0; first `m_valid` 2 cycles after `s_valid`.
- All 4 channels continuously valid, each block 2 words → grant order 0,1,2,3,0, with one IDLE bubble between blocks.
- `MAX_BLOCK_WORDS`=4, channel 2 sends 6 words with `s_last` on word 6 →
  - Block 1: 4 words with `m_last`=`m_cut`=1.
  - Channel 2 re-arbitrates.
  - Block 2: 2 words with `m_sob` on word 5, `m_last` on word 6, `m_cut`=0.
- `m_ready` held 0 for 5 cycles mid-block → `m_*` stable, `s_ready[owner]`=0, no word lost or duplicated.
- `ch_enable[0]` cleared while channel 0 owns a block → block completes; channel 0 is not granted again while disabled.
- Reset asserted mid-block → all outputs 0 immediately. After release, with channels 0 and 3 valid, channel 0 is granted first. With `GZIP_ARB_STATS_EN` defined, counters read 0.
